apb_initiator: RTL and testbench

- Single-outstanding APB3 requester that converts a valid/ready request stream into APB SETUP/ACCESS transfers and returns the result on a valid/ready response stream.
- It drives peripheral-side APB buses such as the console/UART port, as the initiator counterpart to mock APB responders on the testbench side.
- It includes a watchdog that aborts a transfer when the responder never raises pready.

---
 rtl/apb_initiator_pkg.sv | 19 +
 rtl/apb_watchdog_cnt.sv | 18 +
 rtl/apb_initiator.sv | 80 ++++++++
 tb/tb_apb_initiator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/apb_initiator_pkg.sv
// apb_initiator_pkg: shared state, request/response types and the watchdog width helper.
package apb_initiator_pkg;
  localparam int ApbAddrW = 32;
  localparam int ApbDataW = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  typedef struct packed {
    logic [ApbAddrW-1:0] addr;
    logic                write;
    logic [ApbDataW-1:0] wdata;
  } apb_init_req_t;
  typedef struct packed {
    logic [ApbDataW-1:0] rdata;
    logic                err;
    logic                timeout;
  } apb_init_resp_t;
  function automatic int wd_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/apb_watchdog_cnt.sv
// apb_watchdog_cnt: saturating ACCESS-phase cycle counter; TimeoutCycles of 0 never expires.
module apb_watchdog_cnt import apb_initiator_pkg::*; #(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = wd_cnt_width(TimeoutCycles);
  localparam logic [CW-1:0] Last = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  localparam logic [CW-1:0] Sat  = CW'(TimeoutCycles);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired_o = (TimeoutCycles != 0) && enable_i && (cnt_q == Last);
  always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != Sat) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB3 requester bridging valid/ready request and response streams.
module apb_initiator import apb_initiator_pkg::*; #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 resp_timeout_o,
  output logic                 busy_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [AddrWidth-1:0] paddr_o,
  output logic [DataWidth-1:0] pwdata_o,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i
);
  apb_state_e     state_q, state_d;
  apb_init_req_t  req_q, req_d;
  apb_init_resp_t resp_q, resp_d;
  logic           expired;
  apb_watchdog_cnt #(.TimeoutCycles(TimeoutCycles)) u_wd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == SETUP),
    .enable_i  (state_q == ACCESS && !pready_i),
    .expired_o (expired)
  );
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? IDLE : state_d;
    req_q   <= rst_i ? '0 : req_d;
    resp_q  <= rst_i ? '0 : resp_d;
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        state_d = SETUP;
        req_d   = '{addr: ApbAddrW'(req_addr_i), write: req_write_i, wdata: ApbDataW'(req_wdata_i)};
      end
      SETUP: state_d = ACCESS;
      // pready is checked first so a ready on the expiry cycle completes normally
      ACCESS: if (pready_i) begin
        state_d = RESP;
        resp_d  = '{rdata: req_q.write ? '0 : ApbDataW'(prdata_i), err: pslverr_i, timeout: 1'b0};
      end else if (expired) begin
        state_d = RESP;
        resp_d  = '{rdata: '0, err: 1'b1, timeout: 1'b1};
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready_o    = state_q == IDLE && !rst_i;
    busy_o         = state_q != IDLE;
    psel_o         = state_q == SETUP || state_q == ACCESS;
    penable_o      = state_q == ACCESS;
    pwrite_o       = req_q.write;
    paddr_o        = req_q.addr[AddrWidth-1:0];
    pwdata_o       = req_q.wdata[DataWidth-1:0];
    resp_valid_o   = state_q == RESP;
    resp_rdata_o   = resp_q.rdata[DataWidth-1:0];
    resp_err_o     = resp_q.err;
    resp_timeout_o = resp_q.timeout;
  end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed bench with a mock APB responder and a response scoreboard.
module tb_apb_initiator;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, resp_timeout, busy, psel, penable, pwrite, pready;
  logic [31:0] resp_rdata, paddr, pwdata;
  logic r_hang = 0, r_err = 0;
  logic [31:0] r_rdata = 0;
  int r_waits = 0, acc_q = 0;
  typedef struct {logic [31:0] rdata; logic err; logic timeout;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;

  apb_initiator #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .resp_timeout_o(resp_timeout), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(r_rdata), .pready_i(pready), .pslverr_i(r_err)
  );

  always #5 clk = ~clk;
  assign pready = psel && penable && !r_hang && (acc_q == r_waits);
  always @(posedge clk) acc_q <= (psel && penable && !pready) ? acc_q + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int waits, input logic hang, input logic err, input logic [31:0] rdata, input int stall);
    exp_t e;
    int acc, k, exp_acc;
    logic to;
    to = hang || waits >= TO;
    exp_acc = to ? TO : waits + 1;
    e.rdata = (to || wr) ? 32'h0 : rdata;
    e.err = to ? 1'b1 : err;
    e.timeout = to;
    r_waits = waits; r_hang = hang; r_err = err; r_rdata = rdata;
    req_valid = 1; req_addr = addr; req_write = wr; req_wdata = wdata;
    chk1({tag, "_req_ready_idle"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 0;
    sb.push_back(e);
    chk1({tag, "_setup_psel"}, psel, 1'b1);
    chk1({tag, "_setup_penable"}, penable, 1'b0);
    chk({tag, "_setup_paddr"}, paddr, addr);
    chk1({tag, "_setup_pwrite"}, pwrite, wr);
    chk({tag, "_setup_pwdata"}, pwdata, wdata);
    chk1({tag, "_setup_req_ready"}, req_ready, 1'b0);
    acc = 0; k = 1;
    while (!resp_valid && k < 40) begin
      @(negedge clk);
      k++;
      if (psel && penable) begin
        acc++;
        chk({tag, "_access_paddr"}, paddr, addr);
        chk({tag, "_access_pwdata"}, pwdata, wdata);
      end
    end
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    if (!resp_valid) return;
    chk({tag, "_access_cycles"}, 32'(acc), 32'(exp_acc));
    chk({tag, "_latency"}, 32'(k), 32'(exp_acc + 2));
    chk1({tag, "_resp_psel"}, psel, 1'b0);
    chk1({tag, "_resp_penable"}, penable, 1'b0);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_rdata"}, resp_rdata, sb[0].rdata);
      chk1({tag, "_stall_err"}, resp_err, sb[0].err);
      chk1({tag, "_stall_req_ready"}, req_ready, 1'b0);
      chk1({tag, "_stall_psel"}, psel, 1'b0);
      @(negedge clk);
      chk1({tag, "_stall_valid"}, resp_valid, 1'b1);
    end
    resp_ready = 1;
    e = sb.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk1({tag, "_err"}, resp_err, e.err);
    chk1({tag, "_timeout"}, resp_timeout, e.timeout);
    @(negedge clk);
    resp_ready = 0;
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_req_ready"}, req_ready, 1'b1);
    chk1({tag, "_idle_resp_valid"}, resp_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    rst = 0;
    @(negedge clk);
    chk1("post_rst_req_ready", req_ready, 1'b1);
    xfer("wr0", 32'h1000_0000, 1'b1, 32'h41, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0);
    xfer("rd3", 32'h1000_0004, 1'b0, 32'h5555, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
    xfer("wrerr", 32'h1000_0008, 1'b1, 32'h77, 1, 1'b0, 1'b1, 32'h1234, 2);
    xfer("timeout", 32'h1000_000C, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'hCAFE, 0);
    xfer("to_edge", 32'h1000_0010, 1'b0, 32'h0, 7, 1'b0, 1'b0, 32'h600D, 0);
    for (int i = 0; i < 4; i++)
      xfer($sformatf("b2b%0d", i), 32'h2000_0000 + 32'(i * 4), 1'(i), 32'h100 + 32'(i), i, 1'b0, 1'b0,
           32'hA000 + 32'(i), i == 1 ? 5 : 0);
    r_hang = 1;
    req_valid = 1; req_addr = 32'h3000_0000; req_write = 0; req_wdata = 32'h9;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    chk1("mid_penable", penable, 1'b1);
    rst = 1;
    @(negedge clk);
    chk1("mid_rst_psel", psel, 1'b0);
    chk1("mid_rst_penable", penable, 1'b0);
    chk1("mid_rst_resp_valid", resp_valid, 1'b0);
    chk1("mid_rst_req_ready", req_ready, 1'b0);
    rst = 0;
    r_hang = 0;
    @(negedge clk);
    chk1("after_rst_req_ready", req_ready, 1'b1);
    chk1("after_rst_busy", busy, 1'b0);
    xfer("rd_after_rst", 32'h3000_0004, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h8765_4321, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
